// File: rtl/ser_tx.sv
// ser_tx: port-mapped 8N1 UART transmitter (LSB first) with a transmit FIFO.
//   clk       rising-edge system clock
//   reset     synchronous active-high reset
//   en        port access strobe (strobe AND address decode)
//   wr        1 = write, 0 = read (only meaningful with en)
//   addr      0 = data register, 1 = status register
//   data_in   CPU write data
//   data_out  registered read data; 0 whenever the previous cycle was not a read
//   txd       serial line, idle high
// Status byte: {4'b0, overflow, busy, empty, full}. Reading it clears overflow.
module ser_tx #(
  parameter int unsigned BAUD_DIVISOR   = 5208,
  parameter int unsigned FIFO_ADDR_BITS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       wr,
  input  logic       addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       txd
);

  localparam int unsigned DEPTH = 1 << FIFO_ADDR_BITS;
  localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIVISOR - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]                mem_q [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wptr_q, rptr_q;
  logic [FIFO_ADDR_BITS:0]   count_q, count_d;
  state_e                    state_q;
  logic [15:0]               baud_q;
  logic [2:0]                bit_q;
  logic [7:0]                shift_q;
  logic                      ovf_q, ovf_d;
  logic [7:0]                data_out_q, data_out_d;
  logic                      txd_q;

  logic empty, full, busy;
  logic wr_data, rd_status, push, pop, ovf_evt;

  assign empty = (count_q == '0);
  // count never exceeds DEPTH, so its MSB is set only when the FIFO is full
  assign full  = count_q[FIFO_ADDR_BITS];
  assign busy  = (state_q != IDLE);

  assign wr_data   = en & wr & ~addr;
  assign rd_status = en & ~wr & addr;

  // The FSM pops from the pre-edge contents, so a push into an empty FIFO
  // is only seen one cycle later; a push into a full FIFO succeeds when the
  // FSM frees the head slot on the same edge.
  assign pop     = (state_q == IDLE) & ~empty;
  assign push    = wr_data & (~full | pop);
  assign ovf_evt = wr_data & full & ~pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // A new overflow wins over the clear from a status read in the same cycle.
  assign ovf_d      = ovf_evt | (ovf_q & ~rd_status);
  assign data_out_d = rd_status ? {4'b0, ovf_q, busy, empty, full} : 8'h00;

  // FIFO storage carries no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      data_out_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      data_out_q <= data_out_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;

      // txd follows the state register one cycle later
      case (state_q)
        START:   txd_q <= 1'b0;
        DATA:    txd_q <= shift_q[0];
        default: txd_q <= 1'b1;
      endcase

      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q <= mem_q[rptr_q];
            baud_q  <= BAUD_RELOAD;
            state_q <= START;
          end
        end
        START: begin
          if (baud_q == '0) begin
            baud_q  <= BAUD_RELOAD;
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        DATA: begin
          if (baud_q == '0) begin
            baud_q  <= BAUD_RELOAD;
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        STOP: begin
          if (baud_q == '0) begin
            baud_q  <= BAUD_RELOAD;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out = data_out_q;
  assign txd      = txd_q;

endmodule

// File: tb/tb_ser_tx.sv
// tb_ser_tx: scoreboard bench for ser_tx. A transaction-level model (byte
// queue plus remaining-frame-time counter) predicts status reads and the
// start cycle of each frame; a monitor decodes txd frames and compares.
module tb_ser_tx;

  localparam int B     = 4;
  localparam int DEPTH = 16;
  localparam int FLEN  = 10 * B;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, wr = 1'b0, addr = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       txd;

  ser_tx #(.BAUD_DIVISOR(B), .FIFO_ADDR_BITS(4)) dut (
    .clk(clk), .reset(reset), .en(en), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .txd(txd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [7:0] act, logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [7:0] b; int t; } frame_t;
  logic [7:0] m_q[$];
  frame_t     exp_q[$];
  int         m_tleft = 0;
  bit         m_ovf = 0;
  logic [7:0] m_dout = 8'h00;
  int         cyc = 0;
  bit         mon_abort = 0;

  initial begin
    bit         pop_m;
    frame_t     f;
    logic [7:0] st;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        m_q.delete();
        exp_q.delete();
        m_tleft = 0;
        m_ovf = 0;
        m_dout = 8'h00;
        mon_abort = 1;
      end else begin
        pop_m = (m_tleft == 0) && (m_q.size() > 0);
        st = {4'b0, m_ovf, m_tleft != 0, m_q.size() == 0, m_q.size() == DEPTH};
        m_dout = (en && !wr && addr) ? st : 8'h00;
        if (en && !wr && addr) m_ovf = 0;
        if (pop_m) begin
          f.b = m_q.pop_front();
          f.t = cyc + 1;
          exp_q.push_back(f);
          m_tleft = FLEN;
        end else if (m_tleft > 0) begin
          m_tleft--;
        end
        if (en && wr && !addr) begin
          if (m_q.size() < DEPTH) m_q.push_back(data_in);
          else m_ovf = 1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  bit         in_frame = 0;
  logic       prev_txd = 1'b1;
  frame_t     cur;
  int         mk, errs, bi;
  logic [7:0] rx;
  logic       lv;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_abort) begin
        in_frame = 0;
        mon_abort = 0;
        prev_txd = 1'b1;
      end
      chk("data_out", data_out, m_dout);
      if (!in_frame && prev_txd === 1'b1 && txd === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame at cycle %0d", cyc);
        end else begin
          cur = exp_q.pop_front();
          checks++;
          if (cyc != cur.t) begin
            failures++;
            $display("FAIL frame_start actual=%0d expected=%0d", cyc, cur.t);
          end
          in_frame = 1;
          mk = 0;
          errs = 0;
          rx = 8'h00;
        end
      end
      if (in_frame) begin
        bi = mk / B;
        if (bi == 0)      lv = 1'b0;
        else if (bi == 9) lv = 1'b1;
        else              lv = cur.b[bi-1];
        if (txd !== lv) errs++;
        if (bi >= 1 && bi <= 8 && (mk % B) == B / 2) rx[bi-1] = txd;
        mk++;
        if (mk == FLEN) begin
          chk("frame_byte", rx, cur.b);
          chk("frame_bit_errors", 8'(errs), 8'h00);
          in_frame = 0;
        end
      end
      prev_txd = txd;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(bit e, bit w, bit a, logic [7:0] d);
    en = e; wr = w; addr = a; data_in = d;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 8'h00);
  endtask

  task automatic rd_status(string nm, logic [7:0] expv);
    drive(1, 0, 1, 8'h00);
    chk(nm, data_out, expv);
    en = 1'b0;
  endtask

  task automatic drain(string nm);
    int n = 0;
    while ((m_q.size() != 0 || m_tleft != 0 || exp_q.size() != 0 || in_frame) && n < 3000) begin
      drive(0, 0, 0, 8'h00);
      n++;
    end
    chk(nm, (n < 3000) ? 8'h01 : 8'h00, 8'h01);
    idle(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit done;
    logic [7:0] z;
    @(negedge clk);
    idle(3);
    reset = 1'b0;
    chk("reset_txd", {7'b0, txd}, 8'h01);
    chk("reset_dout", data_out, 8'h00);
    rd_status("reset_status", 8'h02);

    // 1: single byte, status during and after the frame
    drive(1, 1, 0, 8'hA5);
    idle(10);
    rd_status("status_busy", 8'h06);
    idle(40);
    rd_status("status_done", 8'h02);
    drain("drain1");

    // 2: back-to-back frames
    drive(1, 1, 0, 8'h00);
    drive(1, 1, 0, 8'hFF);
    drain("drain2");

    // 3: overflow while busy
    drive(1, 1, 0, 8'h3C);
    idle(3);
    for (int i = 0; i < 17; i++) drive(1, 1, 0, 8'(8'h10 + i));
    rd_status("status_full_ovf", 8'h0D);
    drive(1, 1, 0, 8'hEE);
    idle(25);
    rd_status("status_ovf_popped", 8'h0C);
    rd_status("status_ovf_cleared", 8'h04);
    drain("drain3");

    // 4: push into a full FIFO on the same edge the FSM pops
    drive(1, 1, 0, 8'h81);
    idle(3);
    for (int i = 0; i < 16; i++) drive(1, 1, 0, 8'(8'h40 + i));
    done = 0;
    k = 0;
    while (!done && k < 100) begin
      if (m_tleft == 0 && m_q.size() == DEPTH) begin
        drive(1, 1, 0, 8'h5A);
        done = 1;
      end else begin
        drive(0, 0, 0, 8'h00);
      end
      k++;
    end
    chk("coincident_found", done ? 8'h01 : 8'h00, 8'h01);
    rd_status("status_coincident", 8'h05);
    drain("drain4");

    // 5: reset mid data bit
    drive(1, 1, 0, 8'hC3);
    idle(12);
    reset = 1'b1;
    drive(0, 0, 0, 8'h00);
    reset = 1'b0;
    chk("midreset_txd", {7'b0, txd}, 8'h01);
    rd_status("midreset_status", 8'h02);
    idle(60);
    drive(1, 1, 0, 8'h96);
    drain("drain5");

    // 6: non-data accesses leave everything unchanged
    for (int i = 0; i < 20; i++) begin
      k = $urandom_range(0, 2);
      z = 8'($urandom);
      if (k == 0) begin
        drive(1, 0, 0, z);
        chk("rd_data_reg", data_out, 8'h00);
      end else if (k == 1) begin
        drive(1, 1, 1, z);
      end else begin
        drive(0, 0, 0, z);
      end
    end
    rd_status("status_after_noop", 8'h02);
    idle(50);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      z = 8'($urandom);
      if (k <= 3)      drive(0, 0, 0, z);
      else if (k <= 6) drive(1, 1, 0, z);
      else if (k == 7) drive(1, 1, 1, z);
      else if (k == 8) drive(1, 0, 0, z);
      else             drive(1, 0, 1, z);
    end
    drain("drain_rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
